// File: rtl/audio_frame_streamer.sv
`default_nettype none
// audio_frame_streamer: ring-buffers audio samples and streams overlapping FRAME_LEN frames
// advancing by HOP as AXI-stream with tlast; counts frames and overflow drops.  Rev 1.0
module audio_frame_streamer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 512,
  parameter int HOP          = 256,
  parameter int DEPTH        = 1024
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [SAMPLE_WIDTH-1:0]   sample_in,
  input  logic                      sample_valid_in,
  output logic [2*SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [15:0]               frame_count_out,
  output logic [15:0]               dropped_count_out,
  output logic                      overflow_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = $clog2(FRAME_LEN) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] FRAME_P = PW'(FRAME_LEN);
  localparam logic [PW-1:0] HOP_P   = PW'(HOP);
  localparam logic [KW-1:0] LAST_K  = KW'(FRAME_LEN - 1);
  localparam logic [KW-1:0] FRAME_K = KW'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]           wp, fs, fs_next, fill, fill_after, rd_ptr;
  logic [KW-1:0]           rd_idx, rd_idx_next;
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] rd_q;
  logic                    inflight, inflight_last;
  logic [SAMPLE_WIDTH-1:0] skid_data [2];
  logic [1:0]              skid_last;
  logic [1:0]              skid_cnt;
  logic [2:0]              occ;
  logic                    wr_en, drop, pop, push, frame_end, rd_en, rd_last;

  assign fill       = wp - fs;
  assign wr_en      = sample_valid_in && (fill != DEPTH_P);
  assign drop       = sample_valid_in && (fill == DEPTH_P);
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign push       = inflight;
  assign frame_end  = pop && skid_last[0];
  assign fs_next    = frame_end ? fs + HOP_P : fs;
  assign fill_after = wp - fs_next;
  // Entries held or in flight once this cycle's pop is taken; two slots cover the RAM latency.
  assign occ        = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign m_axis_tvalid = (skid_cnt != 2'd0);
  assign m_axis_tdata  = {skid_data[0], {SAMPLE_WIDTH{1'b0}}};
  assign m_axis_tlast  = m_axis_tvalid && skid_last[0];

  always_comb begin
    state_next  = state;
    rd_en       = 1'b0;
    rd_ptr      = fs;
    rd_last     = 1'b0;
    rd_idx_next = rd_idx;
    case (state)
      IDLE: begin
        if (fill >= FRAME_P) begin
          rd_en       = 1'b1;
          rd_idx_next = KW'(1);
          state_next  = PRIME;
        end
      end
      PRIME, STREAM: begin
        if (state == PRIME) state_next = STREAM;
        if (frame_end) begin
          if (fill_after >= FRAME_P) begin
            rd_en       = 1'b1;
            rd_ptr      = fs_next;
            rd_idx_next = KW'(1);
            state_next  = PRIME;
          end else begin
            rd_idx_next = '0;
            state_next  = IDLE;
          end
        end else if (rd_idx != FRAME_K && occ < 3'd2) begin
          rd_en       = 1'b1;
          rd_ptr      = fs + PW'(rd_idx);
          rd_last     = (rd_idx == LAST_K);
          rd_idx_next = rd_idx + KW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wp[AW-1:0]] <= sample_in;
    if (rd_en) rd_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      wp                <= '0;
      fs                <= '0;
      rd_idx            <= '0;
      inflight          <= 1'b0;
      inflight_last     <= 1'b0;
      skid_data[0]      <= '0;
      skid_data[1]      <= '0;
      skid_last         <= '0;
      skid_cnt          <= '0;
      frame_count_out   <= '0;
      dropped_count_out <= '0;
      overflow_out      <= 1'b0;
    end else begin
      state         <= state_next;
      rd_idx        <= rd_idx_next;
      fs            <= fs_next;
      inflight      <= rd_en;
      inflight_last <= rd_last;
      if (wr_en) wp <= wp + PW'(1);
      if (drop) begin
        overflow_out <= 1'b1;
        if (dropped_count_out != 16'hFFFF) dropped_count_out <= dropped_count_out + 16'd1;
      end
      if (frame_end) frame_count_out <= frame_count_out + 16'd1;
      case ({push, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            skid_data[0] <= rd_q;
            skid_last[0] <= inflight_last;
          end else begin
            skid_data[1] <= rd_q;
            skid_last[1] <= inflight_last;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid_data[0] <= skid_data[1];
          skid_last[0] <= skid_last[1];
          skid_cnt     <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid_data[0] <= rd_q;
            skid_last[0] <= inflight_last;
          end else begin
            skid_data[0] <= skid_data[1];
            skid_last[0] <= skid_last[1];
            skid_data[1] <= rd_q;
            skid_last[1] <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_audio_frame_streamer.sv
`default_nettype none
// tb_audio_frame_streamer: randomized stimulus checked against a sample-list model of framing,
// overlap, overflow and reset; a second instance covers HOP == FRAME_LEN and saturation.
module tb_audio_frame_streamer;
  localparam int FL = 8;
  localparam int HOP = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, svalid, tready;
  logic [15:0] sample;
  logic [31:0] tdata;
  logic        tvalid, tlast, ovf;
  logic [15:0] fcnt, dcnt;

  logic        rst2, sv2, rdy2;
  logic [15:0] smp2;
  logic [31:0] tdata2;
  logic        tvalid2, tlast2, ovf2;
  logic [15:0] fcnt2, dcnt2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int acc[$];
  int got[$];
  int got_cyc[$];
  int m_fs, beat_k, m_drop, first_valid_cyc, last_wr_cyc;
  bit prev_stall;
  logic [31:0] prev_data;
  logic prev_last;

  audio_frame_streamer #(.SAMPLE_WIDTH(16), .FRAME_LEN(FL), .HOP(HOP), .DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .sample_valid_in(svalid),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready),
    .frame_count_out(fcnt), .dropped_count_out(dcnt), .overflow_out(ovf)
  );

  audio_frame_streamer #(.SAMPLE_WIDTH(16), .FRAME_LEN(FL), .HOP(8), .DEPTH(DEPTH)) dut2 (
    .clk_in(clk), .rst_in(rst2), .sample_in(smp2), .sample_valid_in(sv2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tlast(tlast2), .m_axis_tready(rdy2),
    .frame_count_out(fcnt2), .dropped_count_out(dcnt2), .overflow_out(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_model;
    acc.delete(); got.delete(); got_cyc.delete();
    m_fs = 0; beat_k = 0; m_drop = 0; first_valid_cyc = -1; last_wr_cyc = 0; prev_stall = 0;
  endtask

  // Accepted-sample list plus frame position; drop decision uses the start before this edge's advance.
  task automatic monitor;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          total++;
          if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last) begin
            bad++;
            $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                     tvalid, tdata, tlast, prev_data, prev_last);
          end
        end
        prev_stall = tvalid && !tready;
        prev_data = tdata;
        prev_last = tlast;
        if (svalid) begin
          last_wr_cyc = cyc;
          if (acc.size() - m_fs < DEPTH) acc.push_back(int'(sample));
          else m_drop++;
        end
        if (tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (tvalid && tready) begin
          got.push_back(int'(tdata[31:16]));
          got_cyc.push_back(cyc);
          total++;
          if (tlast !== (beat_k == FL - 1) || tdata[15:0] !== 16'h0) begin
            bad++;
            $display("FAIL beat_format: got last=%b low=%h, need last=%b low=0000",
                     tlast, tdata[15:0], (beat_k == FL - 1));
          end
          beat_k++;
          if (beat_k == FL) begin
            beat_k = 0;
            m_fs += HOP;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic r);
    @(posedge clk);
    #1;
    svalid = v;
    sample = s;
    tready = r;
  endtask

  // mode 0: tready low, 1: tready high, 2: tready random
  task automatic drain(input int n, input int budget, input int mode);
    for (int c = 0; c < budget && got.size() < n; c++)
      drive(1'b0, 16'h0, (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1));
  endtask

  task automatic do_reset;
    rst = 1'b1; svalid = 1'b0; tready = 1'b0; sample = '0;
    @(posedge clk);
    #1;
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; svalid = 1'b0; tready = 1'b0; sample = '0;
    #1;
    total += 6;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b need 0", tvalid); end
    if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b need 0", tlast); end
    if (tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h need 0", tdata); end
    if (fcnt !== 16'h0) begin bad++; $display("FAIL reset_frames: got %h need 0", fcnt); end
    if (dcnt !== 16'h0) begin bad++; $display("FAIL reset_dropped: got %h need 0", dcnt); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b need 0", ovf); end
    do_reset();
  endtask

  task automatic test_basic;
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1);
    drain(8, 30, 1);
    total++;
    if (got.size() != 8) begin bad++; $display("FAIL basic_count: got %0d beats need 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      total++;
      if (got[i] != i + 1) begin bad++; $display("FAIL basic_data[%0d]: got %0d need %0d", i, got[i], i + 1); end
    end
    total += 3;
    if (got_cyc.size() == 8 && got_cyc[7] - got_cyc[0] != 7) begin
      bad++; $display("FAIL basic_no_bubble: got span %0d need 7", got_cyc[7] - got_cyc[0]);
    end
    if (first_valid_cyc - last_wr_cyc - 1 > 3) begin
      bad++; $display("FAIL basic_latency: got %0d need <=3", first_valid_cyc - last_wr_cyc - 1);
    end
    if (fcnt !== 16'd1) begin bad++; $display("FAIL basic_frames: got %0d need 1", fcnt); end
    drive(1'b0, 16'h0, 1'b1);
    total++;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL basic_idle: got tvalid %b need 0", tvalid); end
  endtask

  task automatic test_overlap;
    for (int i = 9; i <= 12; i++) drive(1'b1, 16'(i), 1'b1);
    drain(16, 30, 1);
    total++;
    if (got.size() != 16) begin bad++; $display("FAIL overlap_count: got %0d need 16", got.size()); end
    for (int j = 0; j < 8 && 8 + j < got.size(); j++) begin
      total++;
      if (got[8 + j] != 5 + j) begin bad++; $display("FAIL overlap_data[%0d]: got %0d need %0d", j, got[8 + j], 5 + j); end
    end
    total += 2;
    if (fcnt !== 16'd2) begin bad++; $display("FAIL overlap_frames: got %0d need 2", fcnt); end
    if (dcnt !== 16'd0) begin bad++; $display("FAIL overlap_dropped: got %0d need 0", dcnt); end
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      while ($urandom_range(0, 1) == 1) drive(1'b0, 16'h0, 1'($urandom_range(0, 1)));
      drive(1'b1, 16'(i), 1'($urandom_range(0, 1)));
    end
    drain(24, 400, 2);
    total++;
    if (got.size() != 24) begin bad++; $display("FAIL bp_count: got %0d need 24", got.size()); end
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < FL; k++)
        if (f * FL + k < got.size()) begin
          total++;
          if (got[f * FL + k] != 1 + f * HOP + k) begin
            bad++; $display("FAIL bp_data[%0d.%0d]: got %0d need %0d", f, k, got[f * FL + k], 1 + f * HOP + k);
          end
        end
    total += 2;
    if (fcnt !== 16'd3) begin bad++; $display("FAIL bp_frames: got %0d need 3", fcnt); end
    if (dcnt !== 16'd0) begin bad++; $display("FAIL bp_dropped: got %0d need 0", dcnt); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      total++;
      if (ovf !== ((i - 1) >= 17)) begin
        bad++; $display("FAIL ovf_sticky_at_%0d: got %b need %b", i - 1, ovf, ((i - 1) >= 17));
      end
    end
    drive(1'b0, 16'h0, 1'b0);
    total += 2;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b need 1", ovf); end
    if (dcnt !== 16'd4) begin bad++; $display("FAIL ovf_dropped: got %0d need 4", dcnt); end
    drain(24, 100, 1);
    drain(25, 10, 1);
    total++;
    if (got.size() != 24) begin bad++; $display("FAIL ovf_count: got %0d need 24", got.size()); end
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < FL; k++)
        if (f * FL + k < got.size()) begin
          total++;
          if (got[f * FL + k] != 1 + f * HOP + k) begin
            bad++; $display("FAIL ovf_data[%0d.%0d]: got %0d need %0d", f, k, got[f * FL + k], 1 + f * HOP + k);
          end
        end
    total++;
    if (fcnt !== 16'd3) begin bad++; $display("FAIL ovf_frames: got %0d need 3", fcnt); end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 1; i <= 20; i++) drive(1'b1, 16'(i), 1'b0);
    drain(10, 100, 1);
    total += 3;
    if (tvalid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid: got %b need 1", tvalid); end
    if (fcnt !== 16'd1) begin bad++; $display("FAIL arst_pre_frames: got %0d need 1", fcnt); end
    if (ovf !== 1'b1) begin bad++; $display("FAIL arst_pre_overflow: got %b need 1", ovf); end
    #1 rst = 1'b1;
    #1;
    total += 5;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b need 0", tvalid); end
    if (tdata !== 32'h0) begin bad++; $display("FAIL arst_tdata: got %h need 0", tdata); end
    if (fcnt !== 16'd0) begin bad++; $display("FAIL arst_frames: got %0d need 0", fcnt); end
    if (dcnt !== 16'd0) begin bad++; $display("FAIL arst_dropped: got %0d need 0", dcnt); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL arst_overflow: got %b need 0", ovf); end
    svalid = 1'b0;
    tready = 1'b0;
    clear_model();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 101; i <= 108; i++) drive(1'b1, 16'(i), 1'b1);
    drain(9, 20, 1);
    total++;
    if (got.size() != 8) begin bad++; $display("FAIL arst_count: got %0d need 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      total++;
      if (got[i] != 101 + i) begin bad++; $display("FAIL arst_data[%0d]: got %0d need %0d", i, got[i], 101 + i); end
    end
    total++;
    if (fcnt !== 16'd1) begin bad++; $display("FAIL arst_frames_after: got %0d need 1", fcnt); end
  endtask

  task automatic test_random;
    int nf;
    do_reset();
    for (int c = 0; c < 120; c++)
      drive($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 7);
    drive(1'b0, 16'h0, 1'b1);
    nf = (acc.size() >= FL) ? (acc.size() - FL) / HOP + 1 : 0;
    drain(nf * FL, 400, 1);
    drain(nf * FL + 1, 10, 1);
    total += 4;
    if (got.size() != nf * FL) begin bad++; $display("FAIL rand_count: got %0d need %0d", got.size(), nf * FL); end
    if (fcnt !== 16'(nf)) begin bad++; $display("FAIL rand_frames: got %0d need %0d", fcnt, nf); end
    if (dcnt !== 16'(m_drop)) begin bad++; $display("FAIL rand_dropped: got %0d need %0d", dcnt, m_drop); end
    if (ovf !== (m_drop > 0)) begin bad++; $display("FAIL rand_overflow: got %b need %b", ovf, (m_drop > 0)); end
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < FL; k++)
        if (f * FL + k < got.size()) begin
          total++;
          if (got[f * FL + k] != acc[f * HOP + k]) begin
            bad++; $display("FAIL rand_data[%0d.%0d]: got %0d need %0d", f, k, got[f * FL + k], acc[f * HOP + k]);
          end
        end
  endtask

  task automatic test_nonoverlap_saturation;
    int q[$];
    int k = 0;
    sv2 = 1'b0; rdy2 = 1'b1; smp2 = '0;
    @(posedge clk);
    #1 rst2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      sv2 = (c < 16);
      smp2 = 16'(c + 1);
      @(negedge clk);
      if (tvalid2 && rdy2) begin
        q.push_back(int'(tdata2[31:16]));
        total++;
        if (tlast2 !== (k == FL - 1)) begin bad++; $display("FAIL hop8_tlast: got %b need %b", tlast2, (k == FL - 1)); end
        k = (k + 1) % FL;
      end
    end
    total += 2;
    if (q.size() != 16) begin bad++; $display("FAIL hop8_count: got %0d need 16", q.size()); end
    if (fcnt2 !== 16'd2) begin bad++; $display("FAIL hop8_frames: got %0d need 2", fcnt2); end
    for (int i = 0; i < q.size() && i < 16; i++) begin
      total++;
      if (q[i] != i + 1) begin bad++; $display("FAIL hop8_data[%0d]: got %0d need %0d", i, q[i], i + 1); end
    end
    // 16 writes refill the empty buffer; every write after that is a drop.
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk);
      #1;
      sv2 = 1'b1;
      smp2 = 16'(n);
      rdy2 = 1'b0;
      if (n == 117) begin
        total++;
        if (dcnt2 !== 16'd100) begin bad++; $display("FAIL sat_partial: got %0d need 100", dcnt2); end
      end
      if (n == 65551) begin
        total++;
        if (dcnt2 !== 16'hFFFE) begin bad++; $display("FAIL sat_edge_minus1: got %h need fffe", dcnt2); end
      end
      if (n == 65552) begin
        total++;
        if (dcnt2 !== 16'hFFFF) begin bad++; $display("FAIL sat_edge: got %h need ffff", dcnt2); end
      end
    end
    @(posedge clk);
    #1 sv2 = 1'b0;
    total += 2;
    if (dcnt2 !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h need ffff", dcnt2); end
    if (ovf2 !== 1'b1) begin bad++; $display("FAIL sat_overflow: got %b need 1", ovf2); end
  endtask

  initial begin
    rst2 = 1'b1; sv2 = 1'b0; rdy2 = 1'b0; smp2 = '0;
    clear_model();
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_overlap();
    test_backpressure();
    test_overflow();
    test_async_reset();
    test_random();
    test_nonoverlap_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
